// File: rtl/ear_in.sv
// EAR pin input conditioner: 2-flop synchronizer, saturating integrator with
// hysteresis, and an edge strobe carrying the width of the pulse just ended.
module ear_in #(
  parameter int unsigned WIDTH = 6,
  parameter int unsigned HI    = 48,
  parameter int unsigned LO    = 15,
  parameter int unsigned PW    = 16
) (
  input  logic          clock_i,
  input  logic          reset_i,
  input  logic          ce_i,
  input  logic          ear_raw_i,
  output logic          ear_o,
  output logic          edge_o,
  output logic [PW-1:0] width_o,
  output logic          rise_o
);

  localparam logic [WIDTH-1:0] HI_L = WIDTH'(HI);
  localparam logic [WIDTH-1:0] LO_L = WIDTH'(LO);

  logic             s1_q, s2_q;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic             ear_q, ear_d;
  logic [PW-1:0]    cnt_q, cnt_d;
  logic [PW-1:0]    width_q;
  logic             rise_q, edge_q;
  logic             chg;

  always_comb begin
    acc_d = acc_q;
    if (ce_i) begin
      if (s2_q && (acc_q != '1))
        acc_d = acc_q + 1'b1;
      else if (!s2_q && (acc_q != '0))
        acc_d = acc_q - 1'b1;
    end
  end

  // Hysteresis works off the registered integrator, so ear lags a crossing by one clock
  always_comb begin
    ear_d = ear_q;
    if (!ear_q && (acc_q >= HI_L))
      ear_d = 1'b1;
    else if (ear_q && (acc_q <= LO_L))
      ear_d = 1'b0;
  end

  assign chg = (ear_d != ear_q);

  always_comb begin
    cnt_d = cnt_q;
    if (chg)
      cnt_d = '0;
    else if (ce_i && (cnt_q != '1))
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      acc_q   <= '0;
      ear_q   <= 1'b0;
      cnt_q   <= '0;
      width_q <= '0;
      rise_q  <= 1'b0;
      edge_q  <= 1'b0;
    end else begin
      s1_q   <= ear_raw_i;
      s2_q   <= s1_q;
      acc_q  <= acc_d;
      ear_q  <= ear_d;
      cnt_q  <= cnt_d;
      edge_q <= chg;
      if (chg) begin
        width_q <= cnt_q;
        rise_q  <= ear_d;
      end
    end
  end

  assign ear_o   = ear_q;
  assign edge_o  = edge_q;
  assign width_o = width_q;
  assign rise_o  = rise_q;

endmodule

// File: doc/ear_in.md
# ear_in

Input-side counterpart of the audio output path. It takes the raw, asynchronous EAR pin from the tape/line-in comparator and produces a clean, glitch-free `ear` level for the ULA port read. It also reports a one-cycle edge strobe and the measured width of each completed pulse, for tape-loading acceleration and diagnostics. It sits between the board pin and the ULA/port-decoder logic, in the same clock domain as the audio DACs.

## Interface

Parameters:
- `WIDTH`, 6: integrator counter width in bits.
- `HI`, 48: integrator level at or above which `ear` goes 1.
- `LO`, 15: integrator level at or below which `ear` goes 0. Constraint: 0 ≤ LO < HI ≤ 2^WIDTH−1.
- `PW`, 16: pulse-width counter width in bits.

Ports:
- `clock`, input, 1: system clock.
- `reset`, input, 1: asynchronous, active-high reset.
- `ce`, input, 1: sample enable; the integrator and width counter advance only when high.
- `ear_raw`, input, 1: EAR pin, asynchronous to `clock`.
- `ear`, output, 1: filtered EAR level.
- `edge`, output, 1: one-cycle strobe when `ear` changes value.
- `width`, output, PW: length of the pulse just ended, in `ce` ticks.
- `rise`, output, 1: level `ear` took at the last edge (1 = rising edge), valid with `edge`.

## Operation

Synchronizer:
- Two flops, `s1 <= ear_raw`, `s2 <= s1`, clocked every cycle regardless of `ce`.
- Both flops reset to 0.

Integrator `acc` (WIDTH bits, reset 0), updated only when `ce` = 1:
- If `s2` = 1 and `acc` ≠ 2^WIDTH−1: `acc <= acc+1`.
- If `s2` = 0 and `acc` ≠ 0: `acc <= acc−1`.
- Otherwise hold. The counter saturates at both ends and never wraps.

Hysteresis, evaluated every cycle from the registered `acc`:
- `ear` = 0 and `acc` ≥ HI: next `ear` = 1.
- `ear` = 1 and `acc` ≤ LO: next `ear` = 0.
- Otherwise hold. `ear` resets to 0.

Edge and width:
- `chg` = (next `ear` ≠ `ear`).
- Internal tick counter `cnt` (PW bits, reset 0).
- On the clock edge where `chg` = 1:
  - `width <= cnt`.
  - `rise <= next ear`.
  - `edge <= 1`.
  - `cnt <= 0`, regardless of `ce`.
- Otherwise:
  - `edge <= 0`.
  - If `ce` = 1 and `cnt` ≠ 2^PW−1: `cnt <= cnt+1`. `cnt` saturates and never wraps.
- `width` and `rise` hold their values between edges.
- Saturation of `cnt` means "pulse ≥ 2^PW−1 ticks"; `width` then reports 2^PW−1.

Reset values:
- `ear` = 0, `edge` = 0, `width` = 0, `rise` = 0.
- All internal registers = 0.
- Reset mid-pulse discards the partial measurement. No `edge` is produced on reset assertion or release.

## Timing

- `ear_raw` to `s2`: 2 clocks.
- From the first `ce` tick that sees the new `s2` level, `acc` needs at least (HI − acc) or (acc − LO) ticks to cross the threshold.
- `ear` changes 1 clock after the `acc` register crosses the threshold.
- `edge`, `width` and `rise` update on the same clock edge as `ear`. `edge` is high for exactly one cycle.
- Minimum spacing between two edges is (HI − LO) `ce` ticks. A glitch on `ear_raw` shorter than that spacing never toggles `ear`.
- With `ce` held 1 and a clean step from `acc` = 0: `ear` rises 2 + HI + 1 clocks after the `ear_raw` transition is sampled.
- `ce` = 0 freezes `acc` and `cnt`. The synchronizer keeps running. A threshold crossing already registered in `acc` still updates `ear`.

## Test plan

Bench parameters: WIDTH=4, HI=12, LO=3, PW=8, `ce` = 1 unless stated.

- Reset, then `ear_raw` = 0 for 50 clocks -> `ear` = 0, `edge` never asserted, `width` = 0.
- `ear_raw` 0→1 step at cycle T -> `ear` = 1 at T+15. `edge` high only at T+15. `rise` = 1. `width` = 8'hFF (saturated since reset).
- Step high, then at the edge wait 20 clocks and step low -> `acc` reaches 15 and holds. `ear` falls once `acc` = 3 (12 ticks after `s2` = 0), 1 clock later. `width` = number of ticks since the rising edge (34). `rise` = 0.
- 5-clock glitch high on `ear_raw` from `acc` = 0 -> `acc` peaks at 5. `ear` stays 0, no `edge`.
- `ce` asserted 1 cycle in 4 during a rising step -> `ear` rises after 12 `ce` ticks, about 48 clocks. `width` counts `ce` ticks, not clocks.
- Assert `reset` asynchronously while `acc` = 10 and `ear` = 1 -> `ear`, `edge`, `width` and `acc` are all 0 immediately. After release with `ear_raw` = 1, a fresh rise occurs at 15 clocks.
